// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, MSB first, start/busy/done handshake.
// Optional build macro DIVIDER_SIGNED_EN selects two's-complement operands and results.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] shq;      // dividend bits shift out the top, quotient bits shift in the bottom
   logic [WIDTH-1:0] prem;
   logic             dbz_pend;

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;
   logic             ge;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

`ifdef DIVIDER_SIGNED_EN
   logic q_neg;
   logic r_neg;
`endif

   always_comb begin
      trial  = {prem, shq[WIDTH-1]};
      ge     = (trial >= {1'b0, dvsr});
      // remainder after a successful subtract is below the divisor, so WIDTH bits hold it exactly
      diff   = trial[WIDTH-1:0] - dvsr;
      q_step = {shq[WIDTH-2:0], ge};
      r_step = ge ? diff : trial[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
      q_fin   = q_neg ? (~q_step + 1'b1) : q_step;
      r_fin   = r_neg ? (~r_step + 1'b1) : r_step;
      dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
      dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
      q_fin   = q_step;
      r_fin   = r_step;
      dvd_mag = dividend;
      dvs_mag = divisor;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         dvsr        <= '0;
         shq         <= '0;
         prem        <= '0;
         dbz_pend    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (state == DONE && dbz_pend) begin
                  // zero divisor: no iteration, raw dividend was parked in shq
                  quotient    <= '1;
                  remainder   <= shq;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  dbz_pend    <= 1'b0;
               end else if (start) begin
                  dvsr        <= dvs_mag;
                  shq         <= (divisor == '0) ? dividend : dvd_mag;
                  prem        <= '0;
                  cnt         <= '0;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  dbz_pend    <= (divisor == '0);
                  state       <= (divisor == '0) ? DONE : RUN;
`ifdef DIVIDER_SIGNED_EN
                  q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg       <= dividend[WIDTH-1];
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               shq  <= q_step;
               prem <= r_step;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  quotient  <= q_fin;
                  remainder <= r_fin;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
